// File: rtl/adc_channel_scheduler.sv
`timescale 1ns/1ps
// adc_channel_scheduler
//
// Runs conversions on the shared 8-channel serial ADC engine. A programmable
// rate divider produces round ticks. Each tick snapshots chan_mask, and every
// enabled channel is then converted once, lowest index first. Each result
// comes back as a channel-tagged sample with a one-cycle valid strobe.
//
// Optional feature: define ADC_SCHED_TIMEOUT_EN to build the conversion
// watchdog. With it defined, a channel whose conversion does not finish
// within TIMEOUT_CYCLES is abandoned and timeout_err is set. Without it,
// WAIT_DONE waits indefinitely and timeout_err stays low.
//
// Ports
//   clock, reset   system clock; asynchronous active-high reset
//   enable         scheduler run enable (also gates the rate divider)
//   chan_mask      channels to convert in each round
//   rate_div       clocks between round ticks (0 behaves as 1)
//   clear_err      clears the sticky error flags (a set event wins)
//   conv_req       level request to the ADC engine, conv_chan = its channel
//   conv_done      one-cycle completion pulse from the engine, with conv_data
//   sample_valid   one-cycle strobe, with sample_chan and sample_data
//   round_done     one-cycle pulse together with the last sample of a round
//   busy           high while a round is in progress
//   overrun        sticky: a tick arrived while a round was in progress
//   timeout_err    sticky: watchdog expired (constant 0 without the feature)
module adc_channel_scheduler #(
    parameter int NCH            = 8,
    parameter int DW             = 12,
    parameter int DIVW           = 16,
    parameter int TIMEOUT_CYCLES = 1024,
    localparam int CW            = (NCH > 1) ? $clog2(NCH) : 1
) (
    input  logic            clock,
    input  logic            reset,
    input  logic            enable,
    input  logic [NCH-1:0]  chan_mask,
    input  logic [DIVW-1:0] rate_div,
    input  logic            clear_err,
    output logic            conv_req,
    output logic [CW-1:0]   conv_chan,
    input  logic            conv_done,
    input  logic [DW-1:0]   conv_data,
    output logic            sample_valid,
    output logic [CW-1:0]   sample_chan,
    output logic [DW-1:0]   sample_data,
    output logic            round_done,
    output logic            busy,
    output logic            overrun,
    output logic            timeout_err
);

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT_DONE, GAP} state_t;

    function automatic logic [CW-1:0] lowest_set(input logic [NCH-1:0] m);
        logic [CW-1:0] idx;
        idx = '0;
        for (int i = NCH - 1; i >= 0; i--) begin
            if (m[i]) idx = CW'(i);
        end
        return idx;
    endfunction

    // ---- rate divider ----
    // The terminal count is captured at each wrap, so a rate_div change only
    // shapes the following period. On the first enabled cycle nothing has
    // been captured yet, so the live value is used directly.
    logic [DIVW-1:0] div_cnt, div_lim, lim_now, lim_eff;
    logic            div_armed, tick;

    always_comb begin
        lim_now = (rate_div == '0) ? '0 : rate_div - DIVW'(1);
        lim_eff = div_armed ? div_lim : lim_now;
        tick    = enable && (div_cnt == lim_eff);
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            div_cnt   <= '0;
            div_lim   <= '0;
            div_armed <= 1'b0;
        end else if (!enable) begin
            div_cnt   <= '0;
            div_armed <= 1'b0;
        end else begin
            div_armed <= 1'b1;
            if (tick) begin
                div_cnt <= '0;
                div_lim <= lim_now;
            end else begin
                div_cnt <= div_cnt + DIVW'(1);
                if (!div_armed) div_lim <= lim_eff;
            end
        end
    end

    // ---- round sequencer ----
    state_t          state, state_n;
    logic [NCH-1:0]  pending, pending_n, cur_bit;
    logic [CW-1:0]   cur_chan, sample_chan_n;
    logic [DW-1:0]   sample_data_n;
    logic            conv_req_n, sample_valid_n, round_done_n, overrun_n;
    logic            retire;

`ifdef ADC_SCHED_TIMEOUT_EN
    localparam int WDW = $clog2(TIMEOUT_CYCLES + 1);
    logic [WDW-1:0]  wd, wd_n;
    logic            timeout_err_n;
`endif

    // pending is a snapshot, so the channel in flight is always its lowest set bit
    assign cur_chan  = lowest_set(pending);
    assign cur_bit   = NCH'(1) << cur_chan;
    assign conv_chan = cur_chan;
    assign busy      = (state != IDLE);

    always_comb begin
        state_n        = state;
        pending_n      = pending;
        conv_req_n     = conv_req;
        sample_valid_n = 1'b0;
        sample_chan_n  = sample_chan;
        sample_data_n  = sample_data;
        round_done_n   = 1'b0;
        overrun_n      = clear_err ? 1'b0 : overrun;
        retire         = 1'b0;
`ifdef ADC_SCHED_TIMEOUT_EN
        wd_n          = wd;
        timeout_err_n = clear_err ? 1'b0 : timeout_err;
`endif

        if (tick && state != IDLE) overrun_n = 1'b1;

        case (state)
            IDLE: begin
                if (tick && chan_mask != '0) begin
                    pending_n = chan_mask;
                    state_n   = ISSUE;
                end
            end
            ISSUE: begin
                if (!enable) begin
                    round_done_n = 1'b1;
                    state_n      = IDLE;
                end else begin
                    conv_req_n = 1'b1;
                    state_n    = WAIT_DONE;
`ifdef ADC_SCHED_TIMEOUT_EN
                    wd_n = '0;
`endif
                end
            end
            WAIT_DONE: begin
                // A completion in the expiry cycle still counts as a success.
                if (conv_done) begin
                    retire         = 1'b1;
                    sample_valid_n = 1'b1;
                    sample_chan_n  = cur_chan;
                    sample_data_n  = conv_data;
                end
`ifdef ADC_SCHED_TIMEOUT_EN
                else if (wd == WDW'(TIMEOUT_CYCLES - 1)) begin
                    retire        = 1'b1;
                    timeout_err_n = 1'b1;
                end else begin
                    wd_n = wd + WDW'(1);
                end
`endif
            end
            GAP: begin
                if (!enable) begin
                    round_done_n = 1'b1;
                    state_n      = IDLE;
                end else begin
                    state_n = ISSUE;
                end
            end
            default: state_n = IDLE;
        endcase

        // The serial transfer cannot be aborted, so losing enable only ends
        // the round once the outstanding channel has retired.
        if (retire) begin
            conv_req_n = 1'b0;
            pending_n  = pending & ~cur_bit;
            if (pending_n == '0 || !enable) begin
                round_done_n = 1'b1;
                state_n      = IDLE;
            end else begin
                state_n = GAP;
            end
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state        <= IDLE;
            pending      <= '0;
            conv_req     <= 1'b0;
            sample_valid <= 1'b0;
            sample_chan  <= '0;
            sample_data  <= '0;
            round_done   <= 1'b0;
            overrun      <= 1'b0;
`ifdef ADC_SCHED_TIMEOUT_EN
            wd           <= '0;
            timeout_err  <= 1'b0;
`endif
        end else begin
            state        <= state_n;
            pending      <= pending_n;
            conv_req     <= conv_req_n;
            sample_valid <= sample_valid_n;
            sample_chan  <= sample_chan_n;
            sample_data  <= sample_data_n;
            round_done   <= round_done_n;
            overrun      <= overrun_n;
`ifdef ADC_SCHED_TIMEOUT_EN
            wd           <= wd_n;
            timeout_err  <= timeout_err_n;
`endif
        end
    end

`ifndef ADC_SCHED_TIMEOUT_EN
    // Watchdog compiled out: the flag is tied low for every legal TIMEOUT_CYCLES.
    assign timeout_err = (TIMEOUT_CYCLES < 0);
`endif

endmodule

// File: tb/tb_adc_channel_scheduler.sv
`timescale 1ns/1ps
module tb_adc_channel_scheduler;

    logic        clock = 1'b0;
    logic        reset;
    logic        enable;
    logic [7:0]  chan_mask;
    logic [15:0] rate_div;
    logic        clear_err;
    logic        conv_req;
    logic [2:0]  conv_chan;
    logic        conv_done;
    logic [11:0] conv_data;
    logic        sample_valid;
    logic [2:0]  sample_chan;
    logic [11:0] sample_data;
    logic        round_done;
    logic        busy;
    logic        overrun;
    logic        timeout_err;

    adc_channel_scheduler #(.NCH(8), .DW(12), .DIVW(16), .TIMEOUT_CYCLES(16)) dut (
        .clock(clock), .reset(reset), .enable(enable), .chan_mask(chan_mask),
        .rate_div(rate_div), .clear_err(clear_err), .conv_req(conv_req),
        .conv_chan(conv_chan), .conv_done(conv_done), .conv_data(conv_data),
        .sample_valid(sample_valid), .sample_chan(sample_chan),
        .sample_data(sample_data), .round_done(round_done), .busy(busy),
        .overrun(overrun), .timeout_err(timeout_err)
    );

    always #5 clock = ~clock;

    int cyc = 0;
    always @(posedge clock) cyc <= cyc + 1;

    typedef struct packed {
        logic [2:0]  ch;
        logic [11:0] d;
        logic        rd;
    } exp_t;

    exp_t exp_q[$];
    int   req_ch[$];
    int   req_cyc[$];
    int   smp_cyc[$];
    int   rd_cyc[$];
    int   rd_cnt = 0;
    int   total  = 0;
    int   bad    = 0;

    int   eng_lat = 20;
    logic mute_en = 1'b0;
    int   mute_ch = 3;

    task automatic chk(input string name, input longint act, input longint req);
        total++;
        if (act != req) begin
            bad++;
            $display("FAIL %s: got %0d (0x%0h), required %0d (0x%0h)", name, act, act, req, req);
        end
    endtask

    task automatic push_exp(input int ch, input int d, input bit rd);
        exp_t e;
        e.ch = ch[2:0];
        e.d  = d[11:0];
        e.rd = rd;
        exp_q.push_back(e);
    endtask

    task automatic step(input int n);
        repeat (n) begin
            @(negedge clock);
            #1;
        end
    endtask

    task automatic wait_rd(input int target, input int budget, input string name);
        int n = 0;
        while (rd_cnt < target && n < budget) begin step(1); n++; end
        if (rd_cnt < target) chk({name, "_rd_wait"}, rd_cnt, target);
    endtask

    task automatic wait_req(input int target, input int budget, input string name);
        int n = 0;
        while (req_ch.size() < target && n < budget) begin step(1); n++; end
        if (req_ch.size() < target) chk({name, "_req_wait"}, req_ch.size(), target);
    endtask

    task automatic wait_smp(input int target, input int budget, input string name);
        int n = 0;
        while (smp_cyc.size() < target && n < budget) begin step(1); n++; end
        if (smp_cyc.size() < target) chk({name, "_smp_wait"}, smp_cyc.size(), target);
    endtask

    task automatic pulse_clear();
        clear_err = 1'b1;
        step(1);
        clear_err = 1'b0;
        step(1);
    endtask

    // Behavioural ADC engine: answers each request with 0xA00+chan after eng_lat cycles.
    initial begin
        int ch;
        conv_done = 1'b0;
        conv_data = '0;
        forever begin
            @(negedge clock);
            if (conv_req && !reset) begin
                ch = int'(conv_chan);
                req_ch.push_back(ch);
                req_cyc.push_back(cyc);
                if (mute_en && ch == mute_ch) begin
                    for (int n = 0; n < 5000 && conv_req; n++) @(negedge clock);
                end else begin
                    repeat (eng_lat - 1) @(negedge clock);
                    conv_data = 12'hA00 + 12'(ch);
                    conv_done = 1'b1;
                    @(negedge clock);
                    conv_done = 1'b0;
                end
            end
        end
    end

    // Scoreboard monitor
    always @(negedge clock) begin
        exp_t e;
        if (sample_valid) begin
            smp_cyc.push_back(cyc);
            if (exp_q.size() == 0) begin
                chk("unexpected_sample_chan", sample_chan, 8);
            end else begin
                e = exp_q.pop_front();
                chk("sample_chan", sample_chan, e.ch);
                chk("sample_data", sample_data, e.d);
                chk("round_done_with_sample", round_done, e.rd);
            end
        end else if (round_done) begin
            chk("round_done_without_sample", round_done, 0);
        end
        if (round_done) begin
            rd_cnt++;
            rd_cyc.push_back(cyc);
        end
    end

    initial begin
        #400000;
        $display("FAIL global_timeout: simulation time %0t exceeded", $time);
        $display("test done: total=%0d bad=%0d", total, bad + 1);
        $fatal(1);
    end

    initial begin
        int c0, b, bs, br;
        reset     = 1'b1;
        enable    = 1'b0;
        chan_mask = '0;
        rate_div  = '0;
        clear_err = 1'b0;
        step(3);
        chk("reset_outputs",
            {conv_req, conv_chan, sample_valid, sample_chan, sample_data,
             round_done, busy, overrun, timeout_err}, 0);
        reset = 1'b0;
        step(2);
        chk("idle_busy", busy, 0);

        // ---- basic round: mask 0x05, rate 100 ----
        chan_mask = 8'h05; rate_div = 16'd100; eng_lat = 20;
        b = req_ch.size(); bs = smp_cyc.size(); br = rd_cnt;
        for (int r = 0; r < 2; r++) begin
            push_exp(0, 12'hA00, 1'b0);
            push_exp(2, 12'hA02, 1'b1);
        end
        c0 = cyc;
        enable = 1'b1;
        wait_rd(br + 2, 400, "basic");
        chan_mask = 8'h00;
        chk("basic_tick_to_req", req_cyc[b] - c0, 101);
        chk("basic_done_to_sample", smp_cyc[bs] - req_cyc[b], 20);
        chk("basic_req_spacing", req_cyc[b + 1] - req_cyc[b], 22);
        chk("basic_req_ch2", req_ch[b + 1], 2);
        chk("basic_round_period", rd_cyc[br + 1] - rd_cyc[br], 100);
        step(3);
        chk("basic_overrun", overrun, 0);
        chk("basic_busy_after", busy, 0);
        chk("basic_queue_empty", exp_q.size(), 0);
        enable = 1'b0;
        step(3);

        // ---- overrun: rate 10, all channels ----
        rate_div = 16'd10; chan_mask = 8'hFF; eng_lat = 20;
        bs = smp_cyc.size(); br = rd_cnt;
        for (int r = 0; r < 2; r++)
            for (int c = 0; c < 8; c++) push_exp(c, 12'hA00 + c, c == 7);
        enable = 1'b1;
        wait_rd(br + 1, 400, "ovr_round1");
        chk("ovr_set", overrun, 1);
        wait_smp(bs + 9, 100, "ovr_round2_start");
        chan_mask = 8'h00;   // snapshot: round 2 must still cover all 8 channels
        wait_rd(br + 2, 400, "ovr_round2");
        chk("ovr_queue_empty", exp_q.size(), 0);
        step(5);
        pulse_clear();
        step(20);
        chk("ovr_cleared", overrun, 0);
        bs = smp_cyc.size(); br = rd_cnt;
        for (int c = 0; c < 8; c++) push_exp(c, 12'hA00 + c, c == 7);
        chan_mask = 8'hFF;
        wait_smp(bs + 1, 100, "ovr_round3_start");
        chan_mask = 8'h00;
        wait_rd(br + 1, 400, "ovr_round3");
        chk("ovr_reset_again", overrun, 1);
        chk("ovr_queue_empty2", exp_q.size(), 0);
        enable = 1'b0;
        step(3);

        // ---- empty mask with rate_div 0, then ch7 back-to-back ----
        pulse_clear();
        rate_div = 16'd0; chan_mask = 8'h00; eng_lat = 5;
        b = req_ch.size(); br = rd_cnt;
        enable = 1'b1;
        step(40);
        chk("empty_no_req", req_ch.size(), b);
        chk("empty_no_overrun", overrun, 0);
        chk("empty_not_busy", busy, 0);
        for (int r = 0; r < 3; r++) push_exp(7, 12'hA07, 1'b1);
        chan_mask = 8'h80;
        wait_rd(br + 3, 200, "ch7");
        chan_mask = 8'h00;
        chk("ch7_req_chan", req_ch[b], 7);
        chk("ch7_spacing1", req_cyc[b + 1] - req_cyc[b], 7);
        chk("ch7_spacing2", req_cyc[b + 2] - req_cyc[b + 1], 7);
        step(10);
        chk("ch7_no_extra_req", req_ch.size(), b + 3);
        chk("ch7_queue_empty", exp_q.size(), 0);
        enable = 1'b0;
        step(3);

        // ---- enable drop while ch1 is outstanding ----
        pulse_clear();
        rate_div = 16'd50; chan_mask = 8'h0F; eng_lat = 20;
        b = req_ch.size(); br = rd_cnt;
        push_exp(0, 12'hA00, 1'b0);
        push_exp(1, 12'hA01, 1'b1);
        enable = 1'b1;
        wait_req(b + 2, 300, "drop");
        enable = 1'b0;
        wait_rd(br + 1, 100, "drop");
        step(60);
        chk("drop_req_count", req_ch.size(), b + 2);
        chk("drop_last_req_ch1", req_ch[b + 1], 1);
        chk("drop_busy", busy, 0);
        chk("drop_queue_empty", exp_q.size(), 0);

        // ---- asynchronous reset during WAIT_DONE ----
        rate_div = 16'd30; chan_mask = 8'h01; eng_lat = 20;
        b = req_ch.size(); bs = smp_cyc.size();
        enable = 1'b1;
        wait_req(b + 1, 100, "areset");
        step(5);
        chk("areset_req_before", conv_req, 1);
        reset = 1'b1;
        enable = 1'b0;
        #1;
        chk("areset_req_drop", conv_req, 0);
        chk("areset_outputs",
            {conv_req, conv_chan, sample_valid, sample_chan, sample_data,
             round_done, busy, overrun, timeout_err}, 0);
        step(2);
        reset = 1'b0;
        step(40);
        chk("areset_no_sample", smp_cyc.size(), bs);
        chk("areset_no_new_req", req_ch.size(), b + 1);
        chk("areset_busy", busy, 0);

`ifdef ADC_SCHED_TIMEOUT_EN
        // ---- watchdog: ch3 never answers ----
        rate_div = 16'd100; chan_mask = 8'h18; eng_lat = 10;
        mute_en = 1'b1; mute_ch = 3;
        b = req_ch.size(); br = rd_cnt;
        push_exp(4, 12'hA04, 1'b1);
        enable = 1'b1;
        wait_req(b + 1, 200, "wdog");
        step(8);
        chk("wdog_not_yet", timeout_err, 0);
        wait_rd(br + 1, 200, "wdog");
        chk("wdog_flag", timeout_err, 1);
        chk("wdog_first_ch3", req_ch[b], 3);
        chk("wdog_then_ch4", req_ch[b + 1], 4);
        chk("wdog_req_spacing", req_cyc[b + 1] - req_cyc[b], 18);
        chan_mask = 8'h00;
        enable = 1'b0;
        mute_en = 1'b0;
        pulse_clear();
        chk("wdog_cleared", timeout_err, 0);
`else
        chk("timeout_err_tied_low", timeout_err, 0);
`endif

        chk("final_queue_empty", exp_q.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/adc_channel_scheduler.md
Name: adc_channel_scheduler

Overview:
- Sequences conversions on the shared 8-channel serial ADC engine.
- A programmable sample-rate divider starts a "round". Each enabled channel in the mask gets one conversion, lowest index first.
- Each result is returned as a channel-tagged sample with a 1-cycle valid strobe.
- Sits between the serial ADC engine and the scope capture/trigger logic. Replaces the free-running fixed-count refresh.

Parameters:
- NCH, 8, number of ADC channels (channel index width = clog2(NCH) = CW)
- DW, 12, sample data width
- DIVW, 16, width of rate divider
- TIMEOUT_CYCLES, 1024, conversion watchdog limit (used only with ADC_SCHED_TIMEOUT_EN)

Ports:
- clock  in  1  system clock (50 MHz)
- reset  in  1  asynchronous active-high reset
- enable  in  1  scheduler run enable
- chan_mask  in  NCH  channels to convert per round
- rate_div  in  DIVW  clocks between round ticks; 0 is treated as 1
- clear_err  in  1  clears sticky error flags
- conv_req  out  1  conversion request to ADC engine (level)
- conv_chan  out  CW  channel for the current request
- conv_done  in  1  1-cycle pulse from engine, result valid
- conv_data  in  DW  result, valid when conv_done=1
- sample_valid  out  1  1-cycle strobe
- sample_chan  out  CW  channel of sample_data
- sample_data  out  DW  registered conversion result
- round_done  out  1  1-cycle pulse after the last channel of a round
- busy  out  1  high while in ISSUE/WAIT_DONE/GAP
- overrun  out  1  sticky: a tick arrived while a round was in progress
- timeout_err  out  1  sticky watchdog flag (constant 0 when feature is off)

Behaviour:
- Reset values: all outputs 0, FSM in IDLE, divider count 0, pending mask 0.
- Divider:
  - Counts while enable=1. Tick is asserted in the cycle count == max(rate_div,1)-1; the count wraps to 0 that cycle.
  - enable=0 clears the count to 0 and suppresses ticks.
  - A rate_div change takes effect at the next wrap.
- FSM states: IDLE, ISSUE, WAIT_DONE, GAP.
  - IDLE: on tick with chan_mask != 0, latch pending = chan_mask, go to ISSUE. Tick with chan_mask == 0 is ignored; no overrun.
  - ISSUE (1 cycle): conv_chan = lowest set bit of pending. conv_req rises at the end of this cycle. Go to WAIT_DONE.
  - WAIT_DONE:
    - conv_req held high and conv_chan stable. conv_done is ignored in all states except WAIT_DONE.
    - On conv_done: next cycle conv_req=0, sample_valid=1, sample_chan=conv_chan, sample_data=conv_data; clear that bit in pending.
    - If pending is now empty, or enable=0: round_done=1 that same cycle, go to IDLE. Otherwise go to GAP.
  - GAP (1 cycle, conv_req=0): go to ISSUE. Guarantees at least 1 idle cycle of conv_req between requests.
- Latency:
  - Tick at cycle T → conv_req high from T+2.
  - conv_done at cycle D → sample_valid at D+1, next conv_req at D+3.
- Tick in any state other than IDLE: set overrun; the tick is dropped. The round in progress is unaffected.
- enable falling mid-round: the outstanding conversion completes (the serial transfer cannot be aborted), its sample is delivered, round_done pulses, then IDLE. No further requests are issued.
- chan_mask changes mid-round have no effect until the next round (pending is a snapshot).
- clear_err clears overrun/timeout_err. If clear_err and a set event occur in the same cycle, set wins.
- Asynchronous reset mid-conversion:
  - conv_req drops immediately.
  - The engine must itself tolerate request removal.
  - Any conv_done arriving after reset release is ignored (FSM in IDLE).

Optional Feature:
- Macro ADC_SCHED_TIMEOUT_EN.
- Defined:
  - A watchdog counts cycles in WAIT_DONE. On reaching TIMEOUT_CYCLES without conv_done: conv_req drops, timeout_err is set, the channel bit is cleared without sample_valid, and the FSM continues via GAP (or IDLE with round_done if pending is empty).
  - conv_done in the same cycle as expiry counts as success.
- Not defined: no watchdog; WAIT_DONE waits indefinitely; timeout_err tied to 0.

Test Plan:
- Basic round: rate_div=100, chan_mask=8'b0000_0101, engine answers 20 cycles after req with data 0xA00+chan → samples (ch0,0xA00) then (ch2,0xA02), round_done with ch2 sample, rounds repeat every 100 cycles, overrun=0.
- Overrun: rate_div=10, chan_mask=8'hFF, engine latency 20 → overrun=1 after the first round; every round still delivers all 8 channels in order 0..7; clear_err → overrun=0, then it re-sets.
- Empty mask / rate_div=0: chan_mask=0, rate_div=0 → conv_req never asserts, overrun stays 0; set chan_mask=8'h80 → ch7 converted back-to-back with a 1-cycle GAP/IDLE spacing.
- Enable drop: chan_mask=8'h0F; deassert enable while ch1 is in WAIT_DONE → ch1 sample delivered, round_done pulses, ch2/ch3 never requested, busy=0.
- Async reset: assert reset during WAIT_DONE → conv_req=0 immediately, all outputs 0; a late conv_done after release produces no sample_valid.
- Timeout (ADC_SCHED_TIMEOUT_EN, TIMEOUT_CYCLES=16): engine never answers ch3 of mask 8'h18 → after 16 cycles timeout_err=1, no ch3 sample, ch4 requested and delivered normally.
